btn_event_ctrl: RTL and testbench



---
 rtl/btn_event_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_btn_event_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_event_ctrl.sv
// rtl/btn_event_ctrl.sv - shared debounce scheduler with clean press event FIFO
//
// One slow sampling tick drives a scan FSM. On each tick the scan visits every
// button in turn, one per clock, through a single integrator/compare datapath.
// A button's debounced level flips after STABLE_CNT consecutive scans in which
// the synchronized input differs from the level. Qualifying flips are queued
// in a small FIFO that the game FSM drains with a valid/ready handshake.
//
// Optional build macro: RELEASE_EVT_EN
//   defined   - release flips (1->0) are queued too, with evt_press = 0
//   undefined - only presses are queued; releases update btn_level only
//
// Ports:
//   clk        in   system clock (100 MHz)
//   rst_n      in   asynchronous active-low reset
//   btn_raw    in   [N_BTN] raw asynchronous button inputs, 1 = pressed
//   evt_valid  out  FIFO head holds an event
//   evt_ready  in   consumer accepts the head this cycle
//   evt_id     out  [IDW] button index of the head event
//   evt_press  out  1 = press, 0 = release (head event)
//   btn_level  out  [N_BTN] current debounced levels
//   overflow   out  sticky: an event was dropped on a full FIFO
//   ovf_clr    in   clears overflow (a simultaneous set wins)

module btn_event_ctrl #(
   parameter int N_BTN      = 4,
   parameter int TICK_DIV   = 250000,
   parameter int STABLE_CNT = 3,
   parameter int FIFO_DEPTH = 4,
   localparam int IDW       = $clog2(N_BTN)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_BTN-1:0] btn_raw,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [IDW-1:0]   evt_id,
   output logic             evt_press,
   output logic [N_BTN-1:0] btn_level,
   output logic             overflow,
   input  logic             ovf_clr
);

   localparam int TW = $clog2(TICK_DIV);
   localparam int PW = $clog2(FIFO_DEPTH);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SCAN = 1'b1;

   logic [N_BTN-1:0] sync1;
   logic [N_BTN-1:0] btn_s;
   logic [TW-1:0]    tick_cnt;
   logic             tick;
   logic [0:0]       state;
   logic [IDW-1:0]   idx;
   logic [3:0]       cnt [N_BTN];

   // shared per-button datapath, steered by the scan index
   logic             cur_s;
   logic             cur_lvl;
   logic [3:0]       cur_cnt;
   logic             differ;
   logic             flip;
   logic             new_lvl;
   logic             push;

   logic [IDW-1:0]   mem_id    [FIFO_DEPTH];
   logic             mem_press [FIFO_DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW:0]      count;
   logic             full;
   logic             do_pop;
   logic             do_write;
   logic [IDW-1:0]   last_id;
   logic             last_press;

   // two-flop synchronizer, free-running
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         btn_s <= '0;
      end else begin
         sync1 <= btn_raw;
         btn_s <= sync1;
      end
   end

   assign tick = (tick_cnt == TW'(TICK_DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tick_cnt <= '0;
      else if (tick) tick_cnt <= '0;
      else tick_cnt <= tick_cnt + TW'(1);
   end

   assign cur_s   = btn_s[idx];
   assign cur_lvl = btn_level[idx];
   assign cur_cnt = cnt[idx];
   assign differ  = (state == ST_SCAN) && (cur_s != cur_lvl);
   assign flip    = differ && (cur_cnt == 4'(STABLE_CNT - 1));
   assign new_lvl = ~cur_lvl;

`ifdef RELEASE_EVT_EN
   assign push = flip;
`else
   assign push = flip && new_lvl;
`endif

   // scan FSM plus integrator update; TICK_DIV > N_BTN+1 keeps ticks out of SCAN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         idx       <= '0;
         btn_level <= '0;
         for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (tick) begin
                  state <= ST_SCAN;
                  idx   <= '0;
               end
            end
            default: begin
               if (!differ) begin
                  cnt[idx] <= '0;
               end else if (flip) begin
                  cnt[idx]       <= '0;
                  btn_level[idx] <= new_lvl;
               end else begin
                  cnt[idx] <= cur_cnt + 4'd1;
               end
               if (idx == IDW'(N_BTN - 1)) begin
                  state <= ST_IDLE;
                  idx   <= '0;
               end else begin
                  idx <= idx + IDW'(1);
               end
            end
         endcase
      end
   end

   assign evt_valid = (count != '0);
   assign full      = (count == (PW + 1)'(FIFO_DEPTH));
   assign do_pop    = evt_valid && evt_ready;
   // a full FIFO still accepts a push when the head leaves in the same cycle
   assign do_write  = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (do_write) begin
         mem_id[wr_ptr]    <= idx;
         mem_press[wr_ptr] <= new_lvl;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         overflow   <= 1'b0;
         last_id    <= '0;
         last_press <= 1'b0;
      end else begin
         if (do_write) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop) begin
            rd_ptr     <= rd_ptr + PW'(1);
            last_id    <= mem_id[rd_ptr];
            last_press <= mem_press[rd_ptr];
         end
         case ({do_write, do_pop})
            2'b10:   count <= count + (PW + 1)'(1);
            2'b01:   count <= count - (PW + 1)'(1);
            default: count <= count;
         endcase
         if (push && full && !do_pop) overflow <= 1'b1;
         else if (ovf_clr) overflow <= 1'b0;
      end
   end

   // when empty the outputs keep showing the most recently consumed event
   assign evt_id    = evt_valid ? mem_id[rd_ptr]    : last_id;
   assign evt_press = evt_valid ? mem_press[rd_ptr] : last_press;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// tb/tb_btn_event_ctrl.sv - randomized and directed bench for btn_event_ctrl

module tb_btn_event_ctrl;

   localparam int NB = 4;
   localparam int TD = 8;
   localparam int SC = 3;
   localparam int FD = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [NB-1:0] btn_raw = '0;
   logic          evt_valid;
   logic          evt_ready = 1'b0;
   logic [1:0]    evt_id;
   logic          evt_press;
   logic [NB-1:0] btn_level;
   logic          overflow;
   logic          ovf_clr = 1'b0;

   btn_event_ctrl #(
      .N_BTN(NB), .TICK_DIV(TD), .STABLE_CNT(SC), .FIFO_DEPTH(FD)
   ) dut (
      .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
      .evt_valid(evt_valid), .evt_ready(evt_ready),
      .evt_id(evt_id), .evt_press(evt_press),
      .btn_level(btn_level), .overflow(overflow), .ovf_clr(ovf_clr)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   // inputs to apply at the next step (sampled on the following rising edge)
   logic [NB-1:0] nxt_raw = '0;
   logic          nxt_ready = 1'b0;
   logic          nxt_clr = 1'b0;
   int            step_no = 0;

   // reference model: edge-counted schedule, per-button rule, event queue
   int            m_k;
   bit [NB-1:0]   m_lvl;
   int            m_cnt [NB];
   bit            m_ovf;
   int            q_id [$];
   bit            q_pr [$];
   int            m_last_id;
   bit            m_last_pr;
   bit [NB-1:0]   raw_q [$];

   // consumed events observed on the DUT
   int            rec_id [$];
   int            rec_pr [$];
   int            rec_step [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (step %0d)", tag, obs, exp, step_no);
      end
   endtask

   task automatic model_reset();
      m_k = 0;
      m_lvl = '0;
      for (int i = 0; i < NB; i++) m_cnt[i] = 0;
      m_ovf = 1'b0;
      q_id.delete();
      q_pr.delete();
      m_last_id = 0;
      m_last_pr = 1'b0;
      raw_q.delete();
   endtask

   // advance the model by the rising edge that just happened
   task automatic model_edge();
      bit [NB-1:0] s_now;
      bit          pop, full0, has_evt, ev_pr, set_ovf;
      int          i, ev_id;
      s_now = (raw_q.size() == 2) ? raw_q[0] : '0;
      raw_q.push_back(btn_raw);
      if (raw_q.size() > 2) void'(raw_q.pop_front());
      full0   = (q_id.size() == FD);
      pop     = (q_id.size() != 0) && evt_ready;
      has_evt = 1'b0;
      ev_pr   = 1'b0;
      ev_id   = 0;
      set_ovf = 1'b0;
      // button i is examined on edge k when k mod TD == i, from the first tick on
      if (m_k >= TD && (m_k % TD) < NB) begin
         i = m_k % TD;
         if (s_now[i] == m_lvl[i]) begin
            m_cnt[i] = 0;
         end else if (m_cnt[i] == SC - 1) begin
            m_lvl[i] = ~m_lvl[i];
            m_cnt[i] = 0;
            ev_pr = m_lvl[i];
            ev_id = i;
`ifdef RELEASE_EVT_EN
            has_evt = 1'b1;
`else
            has_evt = ev_pr;
`endif
         end else begin
            m_cnt[i]++;
         end
      end
      if (pop) begin
         m_last_id = q_id.pop_front();
         m_last_pr = q_pr.pop_front();
      end
      if (has_evt) begin
         if (full0 && !pop) set_ovf = 1'b1;
         else begin
            q_id.push_back(ev_id);
            q_pr.push_back(ev_pr);
         end
      end
      if (set_ovf) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      m_k++;
   endtask

   task automatic check_all();
      chk("valid", evt_valid, q_id.size() != 0);
      chk("level", btn_level, m_lvl);
      chk("overflow", overflow, m_ovf);
      if (q_id.size() != 0) begin
         chk("head_id", evt_id, q_id[0]);
         chk("head_press", evt_press, q_pr[0]);
      end else begin
         chk("hold_id", evt_id, m_last_id);
         chk("hold_press", evt_press, m_last_pr);
      end
   endtask

   task automatic step();
      @(negedge clk);
      if (rst_n) model_edge();
      check_all();
      btn_raw   = nxt_raw;
      evt_ready = nxt_ready;
      ovf_clr   = nxt_clr;
      step_no++;
      if (rst_n && evt_valid && evt_ready) begin
         rec_id.push_back(int'(evt_id));
         rec_pr.push_back(int'(evt_press));
         rec_step.push_back(step_no);
      end
   endtask

   task automatic run(input int n);
      for (int j = 0; j < n; j++) step();
   endtask

   task automatic clear_rec();
      rec_id.delete();
      rec_pr.delete();
      rec_step.delete();
   endtask

   task automatic do_reset(input logic [NB-1:0] raw, input logic rdy);
      rst_n = 1'b0;
      model_reset();
      clear_rec();
      nxt_raw = raw;  nxt_ready = rdy;  nxt_clr = 1'b0;
      btn_raw = raw;  evt_ready = rdy;  ovf_clr = 1'b0;
      #1;
      chk("rst_valid", evt_valid, 0);
      chk("rst_id", evt_id, 0);
      chk("rst_press", evt_press, 0);
      chk("rst_level", btn_level, 0);
      chk("rst_ovf", overflow, 0);
      step();
      step();
      rst_n = 1'b1;
      step_no = 0;
   endtask

   function automatic logic [NB-1:0] ovf_raw(input int s);
      if (s < 30) return 4'b1111;
      else if (s < 60) return 4'b0000;
      else return 4'b0010;
   endfunction

   initial begin
      int exp_b [4];
      bit lvl0_seen;
      int stall;
      #2;

      // steady press on button 2
      do_reset(4'b0100, 1'b1);
      run(48);
      chk("s1_count", rec_id.size(), 1);
      if (rec_id.size() > 0) begin
         chk("s1_id", rec_id[0], 2);
         chk("s1_press", rec_pr[0], 1);
         chk("s1_step", rec_step[0], 27);
      end
      chk("s1_level", btn_level, 4'b0100);
      chk("s1_ovf", overflow, 0);

      // bounce on button 0: toggles every tick, then held low
      do_reset(4'b0000, 1'b1);
      lvl0_seen = 1'b0;
      for (int s = 1; s <= 136; s++) begin
         if (s <= 96 && (s % TD) == 0) nxt_raw[0] = ~nxt_raw[0];
         if (s > 96) nxt_raw[0] = 1'b0;
         step();
         lvl0_seen |= btn_level[0];
      end
      chk("s2_count", rec_id.size(), 0);
      chk("s2_level_seen", lvl0_seen, 0);

      // simultaneous press on all buttons
      do_reset(4'b1111, 1'b1);
      run(40);
      chk("s3_count", rec_id.size(), 4);
      for (int j = 0; j < 4; j++) begin
         if (rec_id.size() > j) begin
            chk("s3_id", rec_id[j], j);
            chk("s3_step", rec_step[j], 25 + j);
         end
      end

`ifndef RELEASE_EVT_EN
      // overflow: fill with four presses, drop a fifth
      do_reset(4'b1111, 1'b0);
      for (int s = 1; s <= 90; s++) begin
         nxt_raw = ovf_raw(s);
         step();
      end
      chk("s4_ovf_set", overflow, 1);
      chk("s4_valid", evt_valid, 1);
      chk("s4_head", evt_id, 0);
      clear_rec();
      nxt_ready = 1'b1;
      run(8);
      chk("s4_drain_n", rec_id.size(), 4);
      for (int j = 0; j < 4; j++)
         if (rec_id.size() > j) chk("s4_drain_id", rec_id[j], j);
      chk("s4_ovf_held", overflow, 1);
      nxt_ready = 1'b0;
      nxt_clr = 1'b1;
      step();
      nxt_clr = 1'b0;
      step();
      chk("s4_ovf_clr", overflow, 0);

      // full FIFO with push and pop on the same edge
      do_reset(4'b1111, 1'b0);
      for (int s = 1; s <= 90; s++) begin
         nxt_raw = ovf_raw(s);
         nxt_ready = (s == 81);
         step();
      end
      chk("s4b_ovf", overflow, 0);
      chk("s4b_valid", evt_valid, 1);
      clear_rec();
      nxt_ready = 1'b1;
      run(8);
      exp_b = '{1, 2, 3, 1};
      chk("s4b_drain_n", rec_id.size(), 4);
      for (int j = 0; j < 4; j++)
         if (rec_id.size() > j) chk("s4b_drain_id", rec_id[j], exp_b[j]);
`endif

      // reset in the middle of a scan
      do_reset(4'b1111, 1'b1);
      run(9);
      do_reset(4'b1111, 1'b1);
      run(40);
      chk("s5_count", rec_id.size(), 4);
      if (rec_step.size() > 0) chk("s5_first", rec_step[0], 25);
      chk("s5_level", btn_level, 4'b1111);

      // press then release button 1
      do_reset(4'b0010, 1'b1);
      for (int s = 1; s <= 64; s++) begin
         if (s == 30) nxt_raw = 4'b0000;
         step();
      end
`ifdef RELEASE_EVT_EN
      chk("s6_count", rec_id.size(), 2);
      if (rec_id.size() > 1) begin
         chk("s6_id0", rec_id[0], 1);
         chk("s6_pr0", rec_pr[0], 1);
         chk("s6_id1", rec_id[1], 1);
         chk("s6_pr1", rec_pr[1], 0);
      end
`else
      chk("s6_count", rec_id.size(), 1);
      if (rec_id.size() > 0) begin
         chk("s6_id0", rec_id[0], 1);
         chk("s6_pr0", rec_pr[0], 1);
      end
`endif
      chk("s6_level", btn_level, 4'b0000);

      // random bouncing inputs, alternating stalled and flowing consumer
      do_reset(4'b0000, 1'b0);
      for (int s = 0; s < 4000; s++) begin
         stall = (s / 250) % 2;
         for (int b = 0; b < NB; b++)
            if ($urandom_range(39) == 0) nxt_raw[b] = ~nxt_raw[b];
         nxt_ready = (stall != 0) ? ($urandom_range(15) == 0) : ($urandom_range(1) == 0);
         nxt_clr = ($urandom_range(29) == 0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
